// File: rtl/output_writeback_unit_pkg.sv
// rtl/output_writeback_unit_pkg.sv - shared derived constants, FSM encoding and sizing helpers
package output_writeback_unit_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  function automatic int calc_ot(input int kernel_size, input int tile_size);
    return tile_size - kernel_size + 1;
  endfunction

  function automatic int calc_acc_w(input int data_w, input int kernel_w);
    return data_w + kernel_w + 12;
  endfunction

  function automatic int calc_ow(input int image_w, input int kernel_size);
    return image_w - kernel_size + 1;
  endfunction

  // Values for the default datapath configuration
  localparam int OT     = calc_ot(3, 4);
  localparam int ACC_W  = calc_acc_w(8, 8);
  localparam int TILE_W = OT * OT * ACC_W;
  localparam int OW     = calc_ow(10, 3);
  localparam int TPR    = OW / OT;

endpackage

// File: rtl/output_writeback_unit_requant_sat.sv
// rtl/output_writeback_unit_requant_sat.sv - ReLU, right shift and unsigned saturation of one accumulator
module requant_sat #(
  parameter int ACC_W = 28,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] q_o
);

  localparam logic [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [ACC_W-1:0] shifted;

  // Negative values are clamped first, so a logical shift is safe here
  assign shifted = acc_i >> SHIFT;

  always_comb begin
    q_o = shifted[OUT_W-1:0];
    if (acc_i[ACC_W-1]) begin
      q_o = '0;
    end else if (shifted > MAX_V) begin
      q_o = '1;
    end
  end

endmodule

// File: rtl/output_writeback_unit.sv
// rtl/output_writeback_unit.sv - captures PE output tiles, requantizes and writes them planar-raster to BRAM
module output_writeback_unit
  import output_writeback_unit_pkg::*;
#(
  parameter int KERNEL_SIZE       = 3,
  parameter int INPUT_TILE_SIZE   = 4,
  parameter int INPUT_IMAGE_WIDTH = 10,
  parameter int INPUT_DATA_WIDTH  = 8,
  parameter int KERNEL_DATA_WIDTH = 8,
  parameter int NUM_PE            = 3,
  parameter int OUT_DATA_WIDTH    = 8,
  parameter int SHIFT             = 4,
  parameter int ADDR_WIDTH        = 15,
  localparam int C_OT     = calc_ot(KERNEL_SIZE, INPUT_TILE_SIZE),
  localparam int C_ACC_W  = calc_acc_w(INPUT_DATA_WIDTH, KERNEL_DATA_WIDTH),
  localparam int C_TILE_W = C_OT * C_OT * C_ACC_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_tile_valid,
  input  logic [NUM_PE*C_TILE_W-1:0]   i_tile_data,
  output logic                         o_busy,
  output logic                         o_bram_en,
  output logic                         o_bram_we,
  output logic [ADDR_WIDTH-1:0]        o_bram_addr,
  output logic [OUT_DATA_WIDTH-1:0]    o_bram_din,
  output logic                         o_frame_done,
  output logic                         o_overflow
);

  localparam int C_OW  = calc_ow(INPUT_IMAGE_WIDTH, KERNEL_SIZE);
  localparam int C_TPR = C_OW / C_OT;
  localparam int C_EPT = C_OT * C_OT;
  localparam int PW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int EW    = (C_EPT > 1) ? $clog2(C_EPT) : 1;
  localparam int TW    = (C_TPR > 1) ? $clog2(C_TPR) : 1;

  state_e                       state_q;
  logic [PW-1:0]                p_q;
  logic [EW-1:0]                e_q;
  logic [TW-1:0]                trow_q;
  logic [TW-1:0]                tcol_q;
  logic [NUM_PE*C_TILE_W-1:0]   buf_q;

  logic                         issue;
  logic [NUM_PE*C_TILE_W-1:0]   src;
  logic [PW-1:0]                ip;
  logic [EW-1:0]                ie;
  logic                         last_wr;
  logic                         last_tile;
  logic [C_ACC_W-1:0]           elem;
  logic [OUT_DATA_WIDTH-1:0]    q_val;
  logic [31:0]                  addr_full;

  // p_q/e_q name the write issued at the next edge; an accepted tile feeds
  // its first element straight from the input so the write lands one cycle later.
  always_comb begin
    issue = 1'b0;
    src   = buf_q;
    ip    = p_q;
    ie    = e_q;
    if (state_q == IDLE) begin
      if (i_tile_valid) begin
        issue = 1'b1;
        src   = i_tile_data;
        ip    = '0;
        ie    = '0;
      end
    end else begin
      issue = 1'b1;
    end
    last_wr   = (32'(ip) == NUM_PE - 1) && (32'(ie) == C_EPT - 1);
    last_tile = (32'(trow_q) == C_TPR - 1) && (32'(tcol_q) == C_TPR - 1);
    elem      = src[(32'(ip) * C_EPT + 32'(ie)) * C_ACC_W +: C_ACC_W];
    addr_full = 32'(ip) * C_OW * C_OW
              + (32'(trow_q) * C_OT + 32'(ie) / C_OT) * C_OW
              + 32'(tcol_q) * C_OT + 32'(ie) % C_OT;
  end

  requant_sat #(
    .ACC_W (C_ACC_W),
    .OUT_W (OUT_DATA_WIDTH),
    .SHIFT (SHIFT)
  ) u_requant_sat (
    .acc_i (elem),
    .q_o   (q_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      p_q          <= '0;
      e_q          <= '0;
      trow_q       <= '0;
      tcol_q       <= '0;
      buf_q        <= '0;
      o_busy       <= 1'b0;
      o_bram_en    <= 1'b0;
      o_bram_we    <= 1'b0;
      o_bram_addr  <= '0;
      o_bram_din   <= '0;
      o_frame_done <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_busy       <= issue;
      o_bram_en    <= issue;
      o_bram_we    <= issue;
      o_bram_addr  <= issue ? addr_full[ADDR_WIDTH-1:0] : '0;
      o_bram_din   <= issue ? q_val : '0;
      o_frame_done <= issue && last_wr && last_tile;

      // IDLE here also covers the cycle showing the last write, so back-to-back tiles are accepted
      if (state_q == WRITE && i_tile_valid) begin
        o_overflow <= 1'b1;
      end
      if (state_q == IDLE && i_tile_valid) begin
        buf_q <= i_tile_data;
      end

      if (issue) begin
        if (last_wr) begin
          state_q <= IDLE;
          p_q     <= '0;
          e_q     <= '0;
          if (32'(tcol_q) == C_TPR - 1) begin
            tcol_q <= '0;
            trow_q <= (32'(trow_q) == C_TPR - 1) ? '0 : trow_q + 1'b1;
          end else begin
            tcol_q <= tcol_q + 1'b1;
          end
        end else begin
          state_q <= WRITE;
          if (32'(ie) == C_EPT - 1) begin
            e_q <= '0;
            p_q <= ip + 1'b1;
          end else begin
            e_q <= ie + 1'b1;
            p_q <= ip;
          end
        end
      end
    end
  end

endmodule
